instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered decode stage: the inverse of the instruction memory encoder. Accepts a 32-bit instruction_code plus its pc from fetch and splits it into opcode, rs, rt, rd, shift_amt, Imm_operand and jump_target fields.
- Classifies each instruction as R, I, J or illegal, and holds the result in a one-entry output register with valid/ready flow control toward execute.
- Halts fetch acceptance after a syscall until software or the testbench pulses resume.

Parameters:
- R_LAST, 6'h14, last R-type opcode (mfhi=0x00 .. nor=0x14)
- I_LAST, 6'h20, last I-type opcode (lui=0x15 .. sb=0x20)
- OPC_SYSCALL, 6'h27, syscall opcode and last legal opcode (J group is 0x21..0x27)
- CNT_W, 32, width of the decoded-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  fetch presents instruction_code/pc
- in_ready  out  1  stage can accept this cycle
- instruction_code  in  32  encoded instruction
- pc  in  32  pc of instruction_code
- flush  in  1  kill the held instruction (branch/jump redirect)
- resume  in  1  one-cycle pulse that leaves HALT
- out_valid  out  1  decoded fields are valid
- out_ready  in  1  execute consumes the decoded instruction
- out_pc  out  32  captured pc
- opcode  out  6  bits [31:26]
- rs, rt, rd, shift_amt  out  5 each  bits [25:21], [20:16], [15:11], [10:6]
- Imm_operand  out  16  bits [15:0]
- imm_sext  out  32  Imm_operand sign-extended
- jump_target  out  26  bits [25:0]
- instr_type  out  2  0=R, 1=I, 2=J, 3=illegal
- is_syscall  out  1  opcode==OPC_SYSCALL
- halted  out  1  FSM is in HALT
- decode_count  out  CNT_W  number of accepted instructions
- illegal_count  out  CNT_W  number of accepted illegal instructions

Behaviour:
- Reset (async, rst=1): state=EMPTY. All registered outputs are 0, including out_valid, halted and both counters. in_ready=0 while rst=1.
- FSM states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready with no new accept.
  - FULL stays FULL on out_ready together with an accept (back-to-back, 1 instr/cycle).
  - Any state -> HALT on accepting a syscall.
  - HALT -> EMPTY on resume, but only after the syscall has been consumed or flushed. Otherwise the resume is remembered in a pending flag and the exit happens at consumption.
- in_ready = !rst && !flush && state!=HALT && (!out_valid || out_ready). This is combinational.
- Accept = in_valid && in_ready. Fields, out_pc, instr_type and is_syscall register on the same edge, so latency is 1 cycle.
- Classification:
  - opcode<=R_LAST: R type. If instruction_code[5:0]!=0 the instruction is illegal.
  - R_LAST<opcode<=I_LAST: I type.
  - I_LAST<opcode<=OPC_SYSCALL: J type.
  - opcode>OPC_SYSCALL: illegal.
- Raw field outputs are always driven from the word regardless of type.
- Illegal instructions still flow out with out_valid=1 and instr_type=3. Execute decides the trap.
- Counters: decode_count increments by 1 per accept. illegal_count increments by 1 per accepted illegal instruction. Both wrap modulo 2^CNT_W with no saturation.
- Flush:
  - Next edge clears out_valid. in_ready is low in the flush cycle, so a simultaneous in_valid is dropped and not counted.
  - Flush does not leave HALT, but it does count as consuming a held syscall.
- out_valid && !out_ready: all outputs hold stable. The held word is never overwritten.
- resume outside HALT is ignored. Multiple resumes in HALT behave as one.
- rst asserted mid-operation: the held instruction is lost immediately and the counters clear.

Decomposition:
- Shared package:
  - opcode localparams for all 40 opcodes (MFHI=0x00 .. SYSCALL=0x27)
  - R_LAST and I_LAST boundaries
  - instr_type encoding constants
  - FSM state encoding (EMPTY, FULL, HALT)
- One natural combinational sub-module, instr_classify: opcode and low bits in, instr_type and is_syscall out. It is reusable by the hazard unit.
- Register stage, FSM and counters stay in instr_decode_stage.

Test Plan:
- add r5,r3,r4: accept 0x08642800, pc=0x10, out_ready=1. Next cycle: out_valid=1, opcode=0x02, rs=3, rt=4, rd=5, shift_amt=0, instr_type=0, out_pc=0x10, decode_count=1.
- addi with negative imm: 0x5822FFFC gives opcode=0x16, rs=1, rt=2, Imm_operand=0xFFFC, imm_sext=0xFFFFFFFC, instr_type=1. Then j 0x84000123 gives jump_target=0x0000123, instr_type=2.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Required: in_ready=0, outputs stable, count unchanged. Release gives one transfer per cycle after that.
- Illegal: 0xC0000000 (opcode 0x30) and 0x08642801 (R-type, nonzero low bits). Both give instr_type=3 and illegal_count=2.
- Syscall: accept 0x9C000000. Required: halted=1 and in_ready=0 for 5 cycles despite in_valid. resume while out_valid=1 and out_ready=0 is deferred; once consumed, the stage returns to EMPTY and in_ready=1.
- Flush + reset: flush with in_valid=1 gives out_valid=0 next cycle and decode_count unchanged. rst asserted mid-FULL clears out_valid, halted and both counters with no clock edge.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: opcode map, type classes and stage FSM encoding.
// Imported by the decode stage, the classifier and the hazard unit.
package instr_decode_stage_pkg;

    // R group
    localparam logic [5:0] OPC_MFHI    = 6'h00;
    localparam logic [5:0] OPC_MFLO    = 6'h01;
    localparam logic [5:0] OPC_ADD     = 6'h02;
    localparam logic [5:0] OPC_ADDU    = 6'h03;
    localparam logic [5:0] OPC_SUB     = 6'h04;
    localparam logic [5:0] OPC_SUBU    = 6'h05;
    localparam logic [5:0] OPC_MULT    = 6'h06;
    localparam logic [5:0] OPC_MULTU   = 6'h07;
    localparam logic [5:0] OPC_DIV     = 6'h08;
    localparam logic [5:0] OPC_DIVU    = 6'h09;
    localparam logic [5:0] OPC_SLT     = 6'h0a;
    localparam logic [5:0] OPC_SLTU    = 6'h0b;
    localparam logic [5:0] OPC_SLL     = 6'h0c;
    localparam logic [5:0] OPC_SRL     = 6'h0d;
    localparam logic [5:0] OPC_SRA     = 6'h0e;
    localparam logic [5:0] OPC_SLLV    = 6'h0f;
    localparam logic [5:0] OPC_SRLV    = 6'h10;
    localparam logic [5:0] OPC_SRAV    = 6'h11;
    localparam logic [5:0] OPC_AND     = 6'h12;
    localparam logic [5:0] OPC_OR      = 6'h13;
    localparam logic [5:0] OPC_NOR     = 6'h14;
    // I group
    localparam logic [5:0] OPC_LUI     = 6'h15;
    localparam logic [5:0] OPC_ADDI    = 6'h16;
    localparam logic [5:0] OPC_ADDIU   = 6'h17;
    localparam logic [5:0] OPC_SLTI    = 6'h18;
    localparam logic [5:0] OPC_ANDI    = 6'h19;
    localparam logic [5:0] OPC_ORI     = 6'h1a;
    localparam logic [5:0] OPC_XORI    = 6'h1b;
    localparam logic [5:0] OPC_LW      = 6'h1c;
    localparam logic [5:0] OPC_SW      = 6'h1d;
    localparam logic [5:0] OPC_LB      = 6'h1e;
    localparam logic [5:0] OPC_LBU     = 6'h1f;
    localparam logic [5:0] OPC_SB      = 6'h20;
    // J group
    localparam logic [5:0] OPC_J       = 6'h21;
    localparam logic [5:0] OPC_JAL     = 6'h22;
    localparam logic [5:0] OPC_JR      = 6'h23;
    localparam logic [5:0] OPC_BEQ     = 6'h24;
    localparam logic [5:0] OPC_BNE     = 6'h25;
    localparam logic [5:0] OPC_BGTZ    = 6'h26;
    localparam logic [5:0] OPC_SYSCALL = 6'h27;

    localparam logic [5:0] R_LAST = OPC_NOR;
    localparam logic [5:0] I_LAST = OPC_SB;

    localparam logic [1:0] TYPE_R       = 2'd0;
    localparam logic [1:0] TYPE_I       = 2'd1;
    localparam logic [1:0] TYPE_J       = 2'd2;
    localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_decode_stage_classify.sv
// Opcode classifier: maps opcode plus function bits to R/I/J/illegal.
// Purely combinational so the hazard unit can share it.
module instr_classify
    import instr_decode_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [1:0] instr_type,
    output logic       is_syscall
);

    always_comb begin
        instr_type = TYPE_ILLEGAL;
        // R-type words reserve the low six bits; anything nonzero there is malformed
        if (opcode <= R_LAST)
            instr_type = (funct == 6'd0) ? TYPE_R : TYPE_ILLEGAL;
        else if (opcode <= I_LAST)
            instr_type = TYPE_I;
        else if (opcode <= OPC_SYSCALL)
            instr_type = TYPE_J;
    end

    assign is_syscall = (opcode == OPC_SYSCALL);

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: one-entry output buffer with valid/ready toward execute,
// field split, classification, syscall halt and decode/illegal counters.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction_code,
    input  logic [31:0]      pc,
    input  logic             flush,
    input  logic             resume,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shift_amt,
    output logic [15:0]      Imm_operand,
    output logic [31:0]      imm_sext,
    output logic [25:0]      jump_target,
    output logic [1:0]       instr_type,
    output logic             is_syscall,
    output logic             halted,
    output logic [CNT_W-1:0] decode_count,
    output logic [CNT_W-1:0] illegal_count
);

    state_t      state, state_nxt;
    logic        pending, pending_nxt;
    logic        out_valid_nxt;
    logic [31:0] word_q;
    logic        accept;
    logic        consumed;
    logic [1:0]  cls_type;
    logic        cls_sys;

    instr_classify u_classify (
        .opcode     (instruction_code[31:26]),
        .funct      (instruction_code[5:0]),
        .instr_type (cls_type),
        .is_syscall (cls_sys)
    );

    assign in_ready = !rst && !flush && (state != HALT) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    // A flush retires the held word just like a transfer does
    assign consumed = out_valid && (out_ready || flush);

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        out_valid_nxt = out_valid;

        if (flush)          out_valid_nxt = 1'b0;
        else if (accept)    out_valid_nxt = 1'b1;
        else if (out_ready) out_valid_nxt = 1'b0;

        case (state)
            EMPTY: begin
                if (accept) state_nxt = cls_sys ? HALT : FULL;
            end
            FULL: begin
                if (accept)                  state_nxt = cls_sys ? HALT : FULL;
                else if (out_ready || flush) state_nxt = EMPTY;
            end
            HALT: begin
                // Resume is only honoured once the syscall has left the buffer
                if (!out_valid) begin
                    if (resume) state_nxt = EMPTY;
                end else if (consumed) begin
                    if (resume || pending) state_nxt = EMPTY;
                end else if (resume) begin
                    pending_nxt = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        if (state_nxt != HALT) pending_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            pending       <= 1'b0;
            out_valid     <= 1'b0;
            word_q        <= '0;
            out_pc        <= '0;
            instr_type    <= TYPE_R;
            is_syscall    <= 1'b0;
            decode_count  <= '0;
            illegal_count <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_valid <= out_valid_nxt;
            if (accept) begin
                word_q       <= instruction_code;
                out_pc       <= pc;
                instr_type   <= cls_type;
                is_syscall   <= cls_sys;
                decode_count <= decode_count + CNT_W'(1);
                if (cls_type == TYPE_ILLEGAL)
                    illegal_count <= illegal_count + CNT_W'(1);
            end
        end
    end

    assign opcode      = word_q[31:26];
    assign rs          = word_q[25:21];
    assign rt          = word_q[20:16];
    assign rd          = word_q[15:11];
    assign shift_amt   = word_q[10:6];
    assign Imm_operand = word_q[15:0];
    assign imm_sext    = {{16{word_q[15]}}, word_q[15:0]};
    assign jump_target = word_q[25:0];
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: stimulus pushes expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_instr_decode_stage;

    logic        clk, rst, in_valid, in_ready, flush, resume, out_valid, out_ready;
    logic        is_syscall, halted;
    logic [31:0] instruction_code, pc, out_pc, imm_sext, decode_count, illegal_count;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shift_amt;
    logic [15:0] Imm_operand;
    logic [25:0] jump_target;
    logic [1:0]  instr_type;

    int passed = 0;
    int total  = 0;
    int exp_dc = 0;
    int exp_ill = 0;

    typedef struct {
        logic [31:0] w;
        logic [31:0] p;
        logic [1:0]  t;
        logic        s;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    instr_decode_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction_code(instruction_code), .pc(pc), .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shift_amt(shift_amt), .Imm_operand(Imm_operand),
        .imm_sext(imm_sext), .jump_target(jump_target), .instr_type(instr_type),
        .is_syscall(is_syscall), .halted(halted), .decode_count(decode_count),
        .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] p,
                        input logic [1:0] t, input logic s);
        int n = 0;
        instruction_code = w;
        pc = p;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout pc=%h: in_ready=%b want 1", p, in_ready);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{w: w, p: p, t: t, s: s});
        exp_dc++;
        if (t == 2'd3) exp_ill++;
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: pc=%h with empty scoreboard", out_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("out_pc", out_pc, mon_e.p);
                chk("opcode", 32'(opcode), 32'(mon_e.w[31:26]));
                chk("rs", 32'(rs), 32'(mon_e.w[25:21]));
                chk("rt", 32'(rt), 32'(mon_e.w[20:16]));
                chk("rd", 32'(rd), 32'(mon_e.w[15:11]));
                chk("shift_amt", 32'(shift_amt), 32'(mon_e.w[10:6]));
                chk("imm", 32'(Imm_operand), 32'(mon_e.w[15:0]));
                chk("imm_sext", imm_sext, {{16{mon_e.w[15]}}, mon_e.w[15:0]});
                chk("jump_target", 32'(jump_target), 32'(mon_e.w[25:0]));
                chk("instr_type", 32'(instr_type), 32'(mon_e.t));
                chk("is_syscall", 32'(is_syscall), 32'(mon_e.s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; resume = 1'b0; out_ready = 1'b0;
        instruction_code = '0; pc = '0;
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_decode_count", decode_count, 0);
        chk("rst_illegal_count", illegal_count, 0);
        chk("rst_out_pc", out_pc, 0);
        rst = 1'b0;
        tick();

        // add r5,r3,r4
        out_ready = 1'b1;
        send(32'h08642800, 32'h10, 2'd0, 1'b0);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_opcode", 32'(opcode), 32'h02);
        chk("add_rs", 32'(rs), 3);
        chk("add_rt", 32'(rt), 4);
        chk("add_rd", 32'(rd), 5);
        chk("add_type", 32'(instr_type), 0);
        chk("add_pc", out_pc, 32'h10);
        chk("add_count", decode_count, 1);
        tick();

        // addi negative imm, then j back-to-back
        send(32'h5822FFFC, 32'h14, 2'd1, 1'b0);
        chk("addi_opcode", 32'(opcode), 32'h16);
        chk("addi_imm", 32'(Imm_operand), 32'hFFFC);
        chk("addi_sext", imm_sext, 32'hFFFFFFFC);
        chk("addi_type", 32'(instr_type), 1);
        send(32'h84000123, 32'h18, 2'd2, 1'b0);
        chk("j_target", 32'(jump_target), 32'h0000123);
        chk("j_type", 32'(instr_type), 2);
        tick();
        chk("count_after_j", decode_count, 32'(exp_dc));

        // backpressure: 3 stalled cycles, then one transfer per cycle
        out_ready = 1'b0;
        send(32'h08A63000, 32'h20, 2'd0, 1'b0);
        instruction_code = 32'h5C430010; pc = 32'h24; in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_pc", out_pc, 32'h20);
            chk("bp_opcode", 32'(opcode), 32'h02);
            chk("bp_count", decode_count, 32'(exp_dc));
            tick();
        end
        out_ready = 1'b1;
        send(32'h5C430010, 32'h24, 2'd1, 1'b0);
        send(32'h88000040, 32'h28, 2'd2, 1'b0);
        tick();
        chk("count_after_bp", decode_count, 32'(exp_dc));

        // illegal encodings
        send(32'hC0000000, 32'h30, 2'd3, 1'b0);
        send(32'h08642801, 32'h34, 2'd3, 1'b0);
        tick();
        chk("illegal_count", illegal_count, 2);
        chk("illegal_count_model", illegal_count, 32'(exp_ill));
        chk("sb_drained_1", 32'(sb.size()), 0);

        // syscall with deferred resume
        out_ready = 1'b0;
        send(32'h9C000000, 32'h40, 2'd2, 1'b1);
        instruction_code = 32'h08642800; pc = 32'h44; in_valid = 1'b1;
        repeat (5) begin
            #1;
            chk("sys_in_ready", 32'(in_ready), 0);
            chk("sys_halted", 32'(halted), 1);
            tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("sys_deferred_halted", 32'(halted), 1);
        chk("sys_held", 32'(out_valid), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("sys_exit_halted", 32'(halted), 0);
        chk("sys_exit_in_ready", 32'(in_ready), 1);
        chk("sys_exit_out_valid", 32'(out_valid), 0);
        chk("count_after_sys", decode_count, 32'(exp_dc));

        // syscall flushed, then resume
        out_ready = 1'b0;
        send(32'h9C000000, 32'h48, 2'd2, 1'b1);
        void'(sb.pop_back());
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sysfl_out_valid", 32'(out_valid), 0);
        chk("sysfl_halted", 32'(halted), 1);
        chk("sysfl_in_ready", 32'(in_ready), 0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("sysfl_resume_halted", 32'(halted), 0);
        chk("sysfl_resume_in_ready", 32'(in_ready), 1);

        // flush with concurrent in_valid
        send(32'h08642800, 32'h50, 2'd0, 1'b0);
        void'(sb.pop_back());
        instruction_code = 32'h5822FFFC; pc = 32'h54; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_count", decode_count, 32'(exp_dc));
        chk("sb_drained_2", 32'(sb.size()), 0);

        // async reset while holding a syscall
        send(32'h9C000000, 32'h60, 2'd2, 1'b1);
        chk("pre_rst_halted", 32'(halted), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_decode_count", decode_count, 0);
        chk("arst_illegal_count", illegal_count, 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
